fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction-fetch stage and multi-cycle stage sequencer. Sits directly upstream of the decode stage.
- Holds the PC and a word-addressed instruction memory. Presents `instruction` to decode and drives the shared 3-bit `stage` bus that every stage gates on.
- Applies branch redirects from the execute stage and halts on the end-of-program flag from decode.

Parameters:
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words (power of two, 2..1024).
- NUM_STAGES, 5, stage codes issued per instruction: 0=fetch, 1=decode, 2=execute, 3=memory, 4=writeback. Legal range 2..7.
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset. Must be word-aligned.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- branch_taken  input  1  from execute; sampled only on the last-stage edge.
- branch_offset  input  32  sign-extended word offset (decode immediate); sampled with branch_taken.
- end_program  input  1  from decode endProgram; sampled on every edge while running.
- imem_we  input  1  instruction-memory load strobe.
- imem_waddr  input  $clog2(IMEM_DEPTH)  load word address.
- imem_wdata  input  32  load data.
- instruction  output  32  fetched instruction, held stable from stage 1 through NUM_STAGES-1.
- pc  output  32  byte address of the instruction in flight.
- pc_plus4  output  32  pc + 4, combinational from pc.
- stage  output  3  current stage code; 3'b111 = idle/halted.
- instr_valid  output  1  high once the first fetch completes; low after reset and when halted.
- halted  output  1  sticky; set by end_program or fault.
- fetch_fault  output  1  sticky; PC word index >= IMEM_DEPTH at fetch.

Behaviour:
- Reset, asynchronous and immediate:
  - pc=RESET_PC, stage=0, instruction=0.
  - instr_valid=0, halted=0, fetch_fault=0.
  - Memory contents are not cleared.
  - Reset asserted mid-instruction abandons that instruction. The first fetch after release happens on the first posedge with reset low.
- State machine, RUN / HALT:
  - RUN: stage increments by 1 on each posedge and wraps from NUM_STAGES-1 to 0.
  - Fetch edge (stage==0):
    - If pc[31:2] < IMEM_DEPTH: instruction <= imem[pc[31:2]], instr_valid <= 1, stage <= 1.
    - Else: fetch_fault <= 1, halted <= 1, stage <= 3'b111, instr_valid <= 0, instruction unchanged.
  - Decode therefore sees stage==1 and the new instruction on the same edge; fetch-to-decode latency is exactly 1 clock.
  - Last-stage edge (stage==NUM_STAGES-1):
    - pc <= branch_taken ? pc + 4 + (branch_offset << 2) : pc + 4.
    - 32-bit modular arithmetic; the result is always word-aligned.
    - branch_taken is ignored at all other stages.
  - end_program high on any RUN edge: halted <= 1, stage <= 3'b111, instr_valid <= 0.
    - Takes priority over the stage increment and the PC update on that same edge. pc freezes at the halting instruction.
  - HALT: all state frozen; only reset leaves HALT. The stage code 3'b111 guarantees no downstream stage re-fires.
- Instruction memory:
  - Synchronous write on posedge when imem_we=1, in any state including HALT.
  - Write and fetch to the same address on one edge: the fetch returns the old data (read-before-write).
- Throughput: one instruction per NUM_STAGES clocks; no overlap between instructions.
- A branch offset wrapping the PC past 2^32 is legal. A resulting out-of-range index faults at the next fetch edge.

Test Plan:
- Sequential fetch:
  - Stimulus: preload imem[0..2]=32'h8E12_0000, 32'h0000_0000, 32'h0000_0000; release reset.
  - Required: stage sequence 0,1,2,3,4,0,...; instruction=32'h8E12_0000 at the first stage==1; pc=0, 4, 8 at each subsequent fetch edge; instr_valid rises after the first edge.
- Forward branch:
  - Stimulus: pc=8, branch_taken=1, branch_offset=3 at stage 4.
  - Required: next fetch at pc=24.
  - Also: branch_taken=1 at stage 2 only → pc=12 (ignored).
- Backward branch:
  - Stimulus: pc=16, branch_offset=32'hFFFF_FFFC (-4) taken.
  - Required: pc=4; the loop repeats with correct fetched words.
- Halt:
  - Stimulus: imem[1]=32'hFC00_0000; end_program pulsed at stage 2 of that instruction.
  - Required: halted=1, stage=3'b111, instr_valid=0, pc stays 4 for 20 clocks; branch_taken and end_program toggling cause no change.
- Fault:
  - Stimulus: IMEM_DEPTH=4; branch to pc=16.
  - Required: at the next stage-0 edge fetch_fault=1, halted=1, stage=3'b111, instruction unchanged.
- Async reset mid-operation:
  - Stimulus: assert reset between edges during stage 3.
  - Required: outputs reset immediately without a clock; after release, fetch restarts from RESET_PC with the memory contents intact.
  - Also: imem write and fetch on the same address/edge → old word fetched.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and its neighbours: execute/decode controls,
// instruction-memory load port, and the fetch outputs every stage gates on.
interface fetch_sequencer_if #(
  parameter int IMEM_DEPTH = 256
) ();
  localparam int AW = $clog2(IMEM_DEPTH);

  logic          branch_taken;
  logic [31:0]   branch_offset;
  logic          end_program;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [31:0]   instruction;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic [2:0]    stage;
  logic          instr_valid;
  logic          halted;
  logic          fetch_fault;

  modport master (
    input  branch_taken, branch_offset, end_program,
    input  imem_we, imem_waddr, imem_wdata,
    output instruction, pc, pc_plus4, stage, instr_valid, halted, fetch_fault
  );

  modport slave (
    output branch_taken, branch_offset, end_program,
    output imem_we, imem_waddr, imem_wdata,
    input  instruction, pc, pc_plus4, stage, instr_valid, halted, fetch_fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch plus multi-cycle stage sequencer: owns PC and imem, issues the stage code.
//   state  | meaning
//   S_RUN  | stage counts 0..NUM_STAGES-1; fetch at 0, PC update at the last stage
//   S_HALT | frozen with stage=3'b111 until reset (end_program or fetch fault)
module fetch_sequencer #(
  parameter int          IMEM_DEPTH = 256,
  parameter int          NUM_STAGES = 5,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  fetch_sequencer_if.master bus
);
  localparam int         AW         = $clog2(IMEM_DEPTH);
  localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);
  localparam logic [2:0] STAGE_IDLE = 3'b111;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  stage_q, stage_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [31:0]   imem [IMEM_DEPTH];
  logic [AW-1:0] fetch_idx;
  logic          fetch_in_range;
  logic [31:0]   branch_bytes;

  assign fetch_idx      = pc_q[AW+1:2];
  assign fetch_in_range = (pc_q[31:2] < 30'(IMEM_DEPTH));
  assign branch_bytes   = {bus.branch_offset[29:0], 2'b00};

  // Memory is deliberately outside the reset domain so program loads survive reset.
  always_ff @(posedge clk) begin
    if (bus.imem_we) imem[bus.imem_waddr] <= bus.imem_wdata;
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (state_q == S_RUN) begin
      if (bus.end_program) begin
        state_d = S_HALT;
        stage_d = STAGE_IDLE;
        valid_d = 1'b0;
      end else if (stage_q == 3'd0) begin
        if (fetch_in_range) begin
          instr_d = imem[fetch_idx];
          valid_d = 1'b1;
          stage_d = 3'd1;
        end else begin
          state_d = S_HALT;
          fault_d = 1'b1;
          stage_d = STAGE_IDLE;
          valid_d = 1'b0;
        end
      end else if (stage_q == LAST_STAGE) begin
        stage_d = 3'd0;
        pc_d    = bus.branch_taken ? pc_q + 32'd4 + branch_bytes : pc_q + 32'd4;
      end else begin
        stage_d = stage_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      stage_q <= 3'd0;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign bus.instruction = instr_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + 32'd4;
  assign bus.stage       = stage_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.fetch_fault = fault_q;
endmodule
